// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and the receiver.
// Contents: frame state enum, default data width, parity helper.
// Parity convention: par_typ=0 -> ~^data, par_typ=1 -> ^data.
package uart_pkg;

  localparam int DATA_W = 8;

  // START is used only by the transmitter; the receiver treats the falling
  // edge seen in IDLE as the start bit and goes straight to DATA.
  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  // Data is zero-extended to 32 bits by the caller; zero padding leaves the
  // XOR reduction unchanged, so any width up to 32 works.
  function automatic logic calc_parity(input logic [31:0] data, input logic par_typ);
    return par_typ ? (^data) : (~^data);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line.
// Ports: clk, reset (sync, active-high), d (async line in), q (synchronized out).
// Both flops reset to 1 so the line reads idle while the chain refills.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start, DATA_WIDTH data bits LSB first, optional parity, one stop bit; one bit per clk.
// Ports: clk, reset (sync active-high), RX_IN, PAR_EN, PAR_TYP in; P_DATA, DATA_VALID, PAR_ERR, STP_ERR, Busy out.
// Optional macro UART_RX_SYNC_EN: RX_IN goes through a 2-flop synchronizer first (+2 cycles latency).
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR,
  output logic                  STP_ERR,
  output logic                  Busy
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  logic rx_bit;

`ifdef UART_RX_SYNC_EN
  uart_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (RX_IN),
    .q     (rx_bit)
  );
`else
  assign rx_bit = RX_IN;
`endif

  uart_state_t           state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [DATA_WIDTH-1:0] shift_reg, shift_nxt;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_nxt;
  logic                  par_en_q, par_en_nxt;
  logic                  par_typ_q, par_typ_nxt;
  logic                  par_bad, par_bad_nxt;
  logic                  dv_q, dv_nxt;
  logic                  pe_q, pe_nxt;
  logic                  se_q, se_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= WAIT_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      shift_reg <= '0;
      p_data_q  <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      par_bad   <= 1'b0;
      dv_q      <= 1'b0;
      pe_q      <= 1'b0;
      se_q      <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      shift_reg <= shift_nxt;
      p_data_q  <= p_data_nxt;
      par_en_q  <= par_en_nxt;
      par_typ_q <= par_typ_nxt;
      par_bad   <= par_bad_nxt;
      dv_q      <= dv_nxt;
      pe_q      <= pe_nxt;
      se_q      <= se_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    shift_nxt   = shift_reg;
    p_data_nxt  = p_data_q;
    par_en_nxt  = par_en_q;
    par_typ_nxt = par_typ_q;
    par_bad_nxt = par_bad;
    dv_nxt      = 1'b0;
    pe_nxt      = 1'b0;
    se_nxt      = 1'b0;

    case (state)
      // Hold off until the line is seen high so a low line after reset or
      // after a framing error is not mistaken for a start bit.
      WAIT_IDLE: begin
        if (rx_bit) state_nxt = IDLE;
      end

      IDLE: begin
        if (!rx_bit) begin
          // Frame options are frozen for the whole frame.
          par_en_nxt  = PAR_EN;
          par_typ_nxt = PAR_TYP;
          par_bad_nxt = 1'b0;
          cnt_nxt     = '0;
          state_nxt   = DATA;
        end
      end

      DATA: begin
        shift_nxt[cnt] = rx_bit;
        cnt_nxt        = cnt + 1'b1;
        if (cnt == LAST_BIT) begin
          cnt_nxt   = '0;
          state_nxt = par_en_q ? PARITY : STOP;
        end
      end

      PARITY: begin
        par_bad_nxt = (rx_bit != calc_parity(32'(shift_reg), par_typ_q));
        state_nxt   = STOP;
      end

      STOP: begin
        if (!rx_bit) begin
          // Framing error: report both errors together if parity also failed.
          se_nxt    = 1'b1;
          pe_nxt    = par_bad;
          state_nxt = WAIT_IDLE;
        end else if (par_bad) begin
          pe_nxt    = 1'b1;
          state_nxt = IDLE;
        end else begin
          p_data_nxt = shift_reg;
          dv_nxt     = 1'b1;
          state_nxt  = IDLE;
        end
      end

      default: state_nxt = WAIT_IDLE;
    endcase
  end

  assign P_DATA     = p_data_q;
  assign DATA_VALID = dv_q;
  assign PAR_ERR    = pe_q;
  assign STP_ERR    = se_q;
  assign Busy       = (state == DATA) || (state == PARITY) || (state == STOP);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are serialized by the bench one bit per clock.
// Inputs driven and outputs sampled on the falling edge of clk.
module tb_uart_rx;

`ifdef UART_RX_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       RX_IN;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_ERR;
  logic       STP_ERR;
  logic       Busy;

  always #5 clk = ~clk;

  uart_rx #(.DATA_WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .RX_IN      (RX_IN),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_ERR    (PAR_ERR),
    .STP_ERR    (STP_ERR),
    .Busy       (Busy)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Strobe monitor: counts and records every strobe seen on a falling edge.
  int         cyc = 0;
  int         n_dv = 0;
  int         n_pe = 0;
  int         n_se = 0;
  int         n_busy = 0;
  int         n_overlap = 0;
  int         n_long = 0;
  logic       dv_prev = 1'b0;
  logic [7:0] dv_dat[$];
  int         dv_cyc[$];

  always @(negedge clk) begin
    cyc++;
    if (DATA_VALID === 1'b1) begin
      n_dv++;
      dv_dat.push_back(P_DATA);
      dv_cyc.push_back(cyc);
    end
    if (PAR_ERR === 1'b1) n_pe++;
    if (STP_ERR === 1'b1) n_se++;
    if (Busy === 1'b1) n_busy++;
    if (DATA_VALID && (PAR_ERR || STP_ERR)) n_overlap++;
    if (DATA_VALID && dv_prev) n_long++;
    dv_prev = DATA_VALID;
  end

  function automatic logic [31:0] get_dat(input int k);
    return (dv_dat.size() > k) ? {24'h0, dv_dat[k]} : 32'hDEAD;
  endfunction

  function automatic int get_cyc(input int k);
    return (dv_cyc.size() > k) ? dv_cyc[k] : -1;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      RX_IN = 1'b1;
    end
  endtask

  // scramble flips PAR_EN/PAR_TYP mid-frame; the receiver must ignore it.
  task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                            input logic stop, input logic scramble);
    @(negedge clk);
    RX_IN = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      RX_IN = d[i];
      if (scramble && i == 3) begin
        PAR_EN  = ~PAR_EN;
        PAR_TYP = ~PAR_TYP;
      end
    end
    if (pen) begin
      @(negedge clk);
      RX_IN = pbit;
    end
    @(negedge clk);
    RX_IN = stop;
  endtask

  int         dv0, pe0, se0, b0;
  logic [7:0] rnd_exp[256];
  logic [7:0] d;
  logic       pen, ptyp, pbit;

  initial begin
    reset   = 1'b1;
    RX_IN   = 1'b1;
    PAR_EN  = 1'b0;
    PAR_TYP = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_p_data", P_DATA, 0);
    check("rst_dv", DATA_VALID, 0);
    check("rst_pe", PAR_ERR, 0);
    check("rst_se", STP_ERR, 0);
    check("rst_busy", Busy, 0);
    reset = 1'b0;
    idle(4);

    // Frame 0xA5, no parity: exact strobe timing and Busy window.
    b0  = n_busy;
    dv0 = n_dv;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (LAT) @(negedge clk);
    @(negedge clk);
    check("a5_dv_on_time", DATA_VALID, 1);
    check("a5_p_data", P_DATA, 8'hA5);
    check("a5_pe", PAR_ERR, 0);
    check("a5_se", STP_ERR, 0);
    check("a5_busy_low", Busy, 0);
    @(negedge clk);
    check("a5_dv_one_cycle", DATA_VALID, 0);
    idle(3);
    check("a5_busy_cycles", n_busy - b0, 9);
    check("a5_dv_count", n_dv - dv0, 1);

    // Frame 0x3C, even-ones parity type 0 -> expected parity bit 1.
    PAR_EN  = 1'b1;
    PAR_TYP = 1'b0;
    dv0 = n_dv;
    pe0 = n_pe;
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b1);
    idle(5);
    check("3c_good_dv", n_dv - dv0, 1);
    check("3c_good_data", get_dat(dv0), 8'h3C);
    check("3c_good_pe", n_pe - pe0, 0);
    // Same frame with the wrong parity bit.
    PAR_EN  = 1'b1;
    PAR_TYP = 1'b0;
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(5);
    check("3c_bad_pe", n_pe - pe0, 1);
    check("3c_bad_dv", n_dv - dv0, 1);
    check("3c_bad_p_data", P_DATA, 8'h3C);

    // Frame 0x81 with stop=0, then a 20-cycle break.
    PAR_EN = 1'b0;
    dv0 = n_dv;
    pe0 = n_pe;
    se0 = n_se;
    send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    check("brk_se_once", n_se - se0, 1);
    check("brk_no_dv", n_dv - dv0, 0);
    check("brk_no_pe", n_pe - pe0, 0);
    check("brk_busy", Busy, 0);
    idle(1);
    send_frame(8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(5);
    check("brk_55_dv", n_dv - dv0, 1);
    check("brk_55_data", get_dat(dv0), 8'h55);

    // Two frames with zero idle gap.
    dv0 = n_dv;
    send_frame(8'h12, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h34, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(5);
    check("b2b_dv", n_dv - dv0, 2);
    check("b2b_data0", get_dat(dv0), 8'h12);
    check("b2b_data1", get_dat(dv0 + 1), 8'h34);
    check("b2b_spacing", get_cyc(dv0 + 1) - get_cyc(dv0), 10);

    // Reset pulse at data bit 4 of 0xFF.
    dv0 = n_dv;
    pe0 = n_pe;
    se0 = n_se;
    @(negedge clk);
    RX_IN = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      RX_IN = 1'b1;
      reset = (i == 4);
    end
    reset = 1'b0;
    @(negedge clk);
    RX_IN = 1'b1;
    idle(6);
    check("rmid_p_data", P_DATA, 0);
    check("rmid_busy", Busy, 0);
    check("rmid_no_dv", n_dv - dv0, 0);
    check("rmid_no_err", (n_pe - pe0) + (n_se - se0), 0);
    send_frame(8'h0F, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(5);
    check("rmid_0f_dv", n_dv - dv0, 1);
    check("rmid_0f_data", get_dat(dv0), 8'h0F);

    // 256 random bytes with random parity settings and gaps of 0..2 cycles.
    dv0 = n_dv;
    pe0 = n_pe;
    se0 = n_se;
    for (int k = 0; k < 256; k++) begin
      d    = 8'($urandom_range(0, 255));
      pen  = 1'($urandom_range(0, 1));
      ptyp = 1'($urandom_range(0, 1));
      pbit = ptyp ? (^d) : (~^d);
      rnd_exp[k] = d;
      PAR_EN  = pen;
      PAR_TYP = ptyp;
      send_frame(d, pen, pbit, 1'b1, 1'b0);
      idle($urandom_range(0, 2));
    end
    idle(6);
    check("rnd_dv_count", n_dv - dv0, 256);
    check("rnd_pe_count", n_pe - pe0, 0);
    check("rnd_se_count", n_se - se0, 0);
    for (int k = 0; k < 256; k++) begin
      check($sformatf("rnd_data_%0d", k), get_dat(dv0 + k), {24'h0, rnd_exp[k]});
    end

    check("strobe_overlap", n_overlap, 0);
    check("dv_width", n_long, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
